// File: rtl/button_event_arbiter.sv
// Button event arbiter: per-button press/long/repeat/release FSMs whose events are
// queued in one-deep slots and serialized round-robin onto a valid/ready port.
package button_event_arbiter_pkg;
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;
endpackage

module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int unsigned N_BUTTONS     = 4,
  parameter int unsigned LONG_PRESS    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic [N_BUTTONS-1:0]         btn,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(N_BUTTONS)-1:0] evt_id,
  output logic [1:0]                   evt_code,
  output logic [N_BUTTONS-1:0]         ovf,
  input  logic                         ovf_clr
);

  localparam int unsigned ID_W = $clog2(N_BUTTONS);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  btn_state_e           state_q     [N_BUTTONS];
  btn_state_e           state_d     [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_q       [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_d       [N_BUTTONS];
  logic [N_BUTTONS-1:0] gen;
  evt_code_e            gen_code    [N_BUTTONS];

  logic [N_BUTTONS-1:0] slot_vld_q;
  logic [N_BUTTONS-1:0] slot_vld_d;
  evt_code_e            slot_code_q [N_BUTTONS];
  evt_code_e            slot_code_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] drop;
  logic [N_BUTTONS-1:0] ovf_d;

  logic [ID_W-1:0]      last_grant_q;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 load;
  logic                 do_grant;

  // Per-button press/long/repeat/release FSM next-state
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      gen[i]      = 1'b0;
      gen_code[i] = EVT_PRESS;
      if (!en) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (btn[i]) begin
              state_d[i]  = ST_PRESSED;
              cnt_d[i]    = '0;
              gen[i]      = 1'b1;
              gen_code[i] = EVT_PRESS;
            end
          end
          ST_PRESSED: begin
            if (!btn[i]) begin
              state_d[i]  = ST_IDLE;
              cnt_d[i]    = '0;
              gen[i]      = 1'b1;
              gen_code[i] = EVT_RELEASE;
            end else if (cnt_q[i] == LONG_LAST) begin
              state_d[i]  = ST_HELD;
              cnt_d[i]    = '0;
              gen[i]      = 1'b1;
              gen_code[i] = EVT_LONG;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!btn[i]) begin
              state_d[i]  = ST_IDLE;
              cnt_d[i]    = '0;
              gen[i]      = 1'b1;
              gen_code[i] = EVT_RELEASE;
            end else if (cnt_q[i] == REPEAT_LAST) begin
              cnt_d[i]    = '0;
              gen[i]      = 1'b1;
              gen_code[i] = EVT_REPEAT;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Round-robin search starting just above the last granted button
  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= N_BUTTONS; k++) begin
      idx = 32'(last_grant_q) + k;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      if (!grant_found && slot_vld_q[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign load     = !evt_valid || evt_ready;
  assign do_grant = load && en && grant_found;

  // Slot update: a granted slot frees up in time to take a same-cycle event
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      slot_vld_d[i]  = slot_vld_q[i] && !(do_grant && (grant_idx == ID_W'(i)));
      slot_code_d[i] = slot_code_q[i];
      drop[i]        = 1'b0;
      if (!en) begin
        slot_vld_d[i] = 1'b0;
      end else if (gen[i]) begin
        if (!slot_vld_d[i]) begin
          slot_vld_d[i]  = 1'b1;
          slot_code_d[i] = gen_code[i];
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
    ovf_d = (ovf & ~{N_BUTTONS{ovf_clr}}) | drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i]     <= ST_IDLE;
        cnt_q[i]       <= '0;
        slot_code_q[i] <= EVT_PRESS;
      end
      slot_vld_q   <= '0;
      ovf          <= '0;
      last_grant_q <= ID_W'(N_BUTTONS - 1);
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_code     <= 2'd0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        slot_code_q[i] <= slot_code_d[i];
      end
      slot_vld_q <= slot_vld_d;
      ovf        <= ovf_d;
      if (load) begin
        evt_valid <= do_grant;
        if (do_grant) begin
          evt_id       <= grant_idx;
          evt_code     <= slot_code_q[grant_idx];
          last_grant_q <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter using short LONG_PRESS/REPEAT_PERIOD values.
module tb_button_event_arbiter;
  localparam int unsigned N = 4;
  localparam logic [1:0] C_PRESS = 2'd0, C_LONG = 2'd1, C_REPEAT = 2'd2, C_RELEASE = 2'd3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic [N-1:0] btn;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [1:0]   evt_code;
  logic [N-1:0] ovf;
  logic         ovf_clr;

  int checks = 0;
  int passed = 0;

  button_event_arbiter #(
    .N_BUTTONS(N), .LONG_PRESS(8), .REPEAT_PERIOD(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .btn(btn),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_code(evt_code), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; btn = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    checks++;
    if ({evt_valid, evt_id, evt_code} !== 5'b0)
      $display("FAIL reset_evt: got %b want 00000", {evt_valid, evt_id, evt_code});
    else passed++;
    checks++;
    if (ovf !== 4'b0) $display("FAIL reset_ovf: got %b want 0000", ovf);
    else passed++;
    reset_n = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", evt_valid);
    else passed++;
  endtask

  // All four press together, release together after the presses drain
  task automatic test_round_robin();
    logic       exp_v;
    logic [1:0] exp_id, exp_code;
    btn = 4'hF; evt_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 4) btn = '0;
      exp_v    = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
      exp_id   = (k <= 4) ? 2'(k - 1) : 2'(k - 6);
      exp_code = (k <= 4) ? C_PRESS : C_RELEASE;
      checks++;
      if (evt_valid !== exp_v || (exp_v && {evt_id, evt_code} !== {exp_id, exp_code}))
        $display("FAIL round_robin k=%0d: got v=%b id=%0d code=%0d want v=%b id=%0d code=%0d",
                 k, evt_valid, evt_id, evt_code, exp_v, exp_id, exp_code);
      else passed++;
    end
    checks++;
    if (ovf !== 4'b0) $display("FAIL round_robin_ovf: got %b want 0000", ovf);
    else passed++;
  endtask

  task automatic test_short_press();
    logic       exp_v;
    logic [1:0] exp_code;
    evt_ready = 1'b1;
    btn[2] = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 2) btn[2] = 1'b0;
      exp_v    = (k == 1) || (k == 4);
      exp_code = (k == 1) ? C_PRESS : C_RELEASE;
      checks++;
      if (evt_valid !== exp_v || (exp_v && {evt_id, evt_code} !== {2'd2, exp_code}))
        $display("FAIL short_press k=%0d: got v=%b id=%0d code=%0d want v=%b id=2 code=%0d",
                 k, evt_valid, evt_id, evt_code, exp_v, exp_code);
      else passed++;
    end
    checks++;
    if (ovf !== 4'b0) $display("FAIL short_press_ovf: got %b want 0000", ovf);
    else passed++;
  endtask

  // PRESS at E0, LONG at E8, REPEAT at E12/E16/E20, RELEASE at E21; port shows them one edge later
  task automatic test_long_press();
    logic       exp_v;
    logic [1:0] exp_code;
    evt_ready = 1'b1;
    btn[0] = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      step();
      if (k == 20) btn[0] = 1'b0;
      exp_v = (k == 1) || (k == 9) || (k == 13) || (k == 17) || (k == 21) || (k == 22);
      case (k)
        1:       exp_code = C_PRESS;
        9:       exp_code = C_LONG;
        22:      exp_code = C_RELEASE;
        default: exp_code = C_REPEAT;
      endcase
      checks++;
      if (evt_valid !== exp_v || (exp_v && {evt_id, evt_code} !== {2'd0, exp_code}))
        $display("FAIL long_press k=%0d: got v=%b id=%0d code=%0d want v=%b id=0 code=%0d",
                 k, evt_valid, evt_id, evt_code, exp_v, exp_code);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    btn[1] = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b0) $display("FAIL bp_e0_valid: got %b want 0", evt_valid);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) btn[1] = 1'b0;
      if (k == 2) btn[1] = 1'b1;
      if (k == 3) btn[1] = 1'b0;
      checks++;
      if ({evt_valid, evt_id, evt_code} !== {1'b1, 2'd1, C_PRESS})
        $display("FAIL bp_hold k=%0d: got v=%b id=%0d code=%0d want v=1 id=1 code=0",
                 k, evt_valid, evt_id, evt_code);
      else passed++;
      checks++;
      if (ovf !== ((k >= 3) ? 4'b0010 : 4'b0000))
        $display("FAIL bp_ovf k=%0d: got %b want %b", k, ovf, (k >= 3) ? 4'b0010 : 4'b0000);
      else passed++;
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if ({evt_valid, evt_id, evt_code} !== {1'b1, 2'd1, C_RELEASE})
      $display("FAIL bp_release: got v=%b id=%0d code=%0d want v=1 id=1 code=3",
               evt_valid, evt_id, evt_code);
    else passed++;
    step();
    checks++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0010)
      $display("FAIL bp_drain: got v=%b ovf=%b want v=0 ovf=0010", evt_valid, ovf);
    else passed++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0) $display("FAIL bp_ovf_clr: got %b want 0000", ovf);
    else passed++;
  endtask

  // en drops while LONG is stalled on the port and a REPEAT is queued behind it
  task automatic test_enable_drop();
    logic       exp_v;
    logic [1:0] exp_code;
    evt_ready = 1'b1;
    btn[3] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      if (k == 8)  evt_ready = 1'b0;
      if (k == 12) en = 1'b0;
      if (k == 13) evt_ready = 1'b1;
      if (k == 15) en = 1'b1;
      if (k == 17) btn[3] = 1'b0;
      exp_v = (k == 1) || (k >= 9 && k <= 13) || (k == 17) || (k == 19);
      if (k >= 9 && k <= 13) exp_code = C_LONG;
      else if (k == 19)      exp_code = C_RELEASE;
      else                   exp_code = C_PRESS;
      checks++;
      if (evt_valid !== exp_v || (exp_v && {evt_id, evt_code} !== {2'd3, exp_code}))
        $display("FAIL enable_drop k=%0d: got v=%b id=%0d code=%0d want v=%b id=3 code=%0d",
                 k, evt_valid, evt_id, evt_code, exp_v, exp_code);
      else passed++;
    end
    checks++;
    if (ovf !== 4'b0) $display("FAIL enable_drop_ovf: got %b want 0000", ovf);
    else passed++;
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    step();
    step();
    checks++;
    if ({evt_valid, evt_id, evt_code} !== {1'b1, 2'd0, C_PRESS})
      $display("FAIL areset_pre: got v=%b id=%0d code=%0d want v=1 id=0 code=0",
               evt_valid, evt_id, evt_code);
    else passed++;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({evt_valid, evt_id, evt_code} !== 5'b0 || ovf !== 4'b0)
      $display("FAIL areset_immediate: got evt=%b ovf=%b want evt=00000 ovf=0000",
               {evt_valid, evt_id, evt_code}, ovf);
    else passed++;
    btn = '0;
    step();
    reset_n = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (evt_valid !== 1'b0) $display("FAIL areset_stale k=%0d: got v=%b want 0", k, evt_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_short_press();
    test_long_press();
    test_backpressure();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Converts the debounced button levels produced by the per-button debounce stages into discrete, timestamp-free user events: press, long-press, auto-repeat and release. It serializes those events from all buttons onto a single valid/ready event port with round-robin fairness. It sits between the debounce instances and the control FSM or CPU interface that consumes button commands.

## Interface
- N_BUTTONS, 4: number of debounced button inputs (2..16).
- LONG_PRESS, 50_000_000: cycles a button must stay high in PRESSED before a LONG event is issued (≥2).
- REPEAT_PERIOD, 10_000_000: cycles between REPEAT events while in HELD (≥2).
- CNT_W, 26: hold-counter width; must satisfy 2^CNT_W > max(LONG_PRESS, REPEAT_PERIOD).
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable. When 0, all button FSMs are forced to IDLE and all pending slots are cleared.
- btn  in  N_BUTTONS  debounced button levels, one bit per button, already synchronous to clk.
- evt_valid  out  1  event output valid.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clock edge.
- evt_id  out  $clog2(N_BUTTONS)  index of the button that produced the event.
- evt_code  out  2  event code: 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE.
- ovf  out  N_BUTTONS  sticky per-button overflow (an event was dropped).
- ovf_clr  in  1  synchronous clear of all ovf bits.

## Operation
- Per-button FSM, states IDLE, PRESSED, HELD, with a CNT_W-bit hold counter.
  - IDLE, btn=1 sampled: go to PRESSED, counter←0, generate PRESS.
  - PRESSED, btn=1: counter+1. When counter==LONG_PRESS-1: go to HELD, counter←0, generate LONG.
  - HELD, btn=1: counter+1. When counter==REPEAT_PERIOD-1: counter←0, generate REPEAT.
  - PRESSED or HELD, btn=0: go to IDLE, counter←0, generate RELEASE. A short press gives PRESS then RELEASE with no LONG.
- Pending slot per button: one valid bit plus a 2-bit code.
  - A generated event is written into the slot if the slot is empty, or if the slot is being granted in the same cycle.
  - Otherwise the new event is dropped, the slot keeps its older event, and ovf[i] is set.
- Output register: holds evt_valid/evt_id/evt_code.
  - Loads when it is empty, or when the current event is accepted (valid && ready) in the same cycle. This allows back-to-back events at one per cycle.
  - On load, the arbiter grants the first pending slot searching upward (with wrap) from last_grant+1, clears that slot, and sets last_grant to the granted index.
  - If no slot is pending, evt_valid drops after acceptance.
- Handshake: while evt_valid=1 and evt_ready=0, evt_id and evt_code stay stable. evt_valid never deasserts without acceptance, except on reset.
- en=0: FSMs go to IDLE, counters and pending slots clear, no events are generated, and no RELEASE is issued. The output register still completes its current handshake. When en returns to 1 with btn already high, a PRESS is generated on the next edge.
- ovf: when set and ovf_clr occur in the same cycle, set wins.
- Counter arithmetic is unsigned and never wraps, because it is reset on every threshold match.

## Timing
- Reset (reset_n=0, asynchronous): all FSMs IDLE, counters 0, slots empty, last_grant = N_BUTTONS-1 (so button 0 is searched first), evt_valid=0, evt_id=0, evt_code=0, ovf=0.
- Deassertion of reset_n is assumed synchronized externally. The first active edge after release behaves as a normal cycle.
- Latency without contention:
  - Edge E0 is the first edge where btn[i]=1 is sampled; the slot is written at E0.
  - evt_valid=1 with evt_id=i, evt_code=PRESS after E1.
- LONG is generated at the edge where PRESSED has sampled btn=1 for LONG_PRESS consecutive edges after entry. Each REPEAT follows REPEAT_PERIOD edges after the previous LONG or REPEAT.
- Reset mid-handshake: evt_valid drops immediately, and the event is lost without setting ovf.

## Test plan
- Single short press: LONG_PRESS=8, btn[2] high for 3 cycles, evt_ready=1 -> PRESS (id 2) 2 edges after rise, then RELEASE (id 2), no LONG, ovf=0.
- Long press with repeats: LONG_PRESS=8, REPEAT_PERIOD=4, btn[0] high for 20 cycles -> PRESS, LONG at 8 cycles, REPEAT every 4 cycles (3 REPEATs), then RELEASE.
- Round-robin fairness: btn[0..3] all rise at the same edge, evt_ready=1 -> PRESS events in id order 0,1,2,3 on consecutive cycles. With a second simultaneous burst after last_grant=3, the order starts again at 0.
- Backpressure and overflow: evt_ready=0, btn[1] pressed then released -> PRESS stays stable on the port; the RELEASE fills the slot; a further press sets ovf[1]=1. Raising evt_ready delivers PRESS then RELEASE. Pulsing ovf_clr returns ovf to 0.
- Enable drop: en=0 while btn[3] is held in HELD -> no RELEASE, the slot is cleared, the in-flight event completes. When en returns to 1 with btn[3]=1, a PRESS is issued.
- Async reset mid-operation: reset_n low between edges while evt_valid=1 -> outputs are 0 immediately. After release, no stale events appear.
